// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-side pointer, full/level and overflow status for a dual-clock FIFO (optional macro: WPTR_DROP_CNT_EN)
module wptr_full_ctrl #(
    parameter int AW       = 4,
    parameter int AFULL_TH = 12
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic          wen,
    input  logic [AW:0]   wq2_rptr,
    output logic [AW:0]   wptr,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_wen,
    output logic          wfull,
    output logic          walmost_full,
    output logic [AW:0]   wlevel,
    output logic          wovf,
`ifdef WPTR_DROP_CNT_EN
    output logic [15:0]   wdrop_cnt,
`endif
    input  logic          wovf_clr
);

    localparam int          PW        = AW + 1;
    localparam logic [AW:0] AFULL_LVL = PW'(AFULL_TH);

    logic [AW:0] wbin;
    logic [AW:0] wbin_nxt;
    logic [AW:0] wgray_nxt;
    logic [AW:0] rbin_s;
    logic [AW:0] level_nxt;
    logic        wfull_val;
    logic        ovf_set;

    // The memory address comes straight from the binary pointer register.
    assign mem_waddr = wbin[AW-1:0];

    // Write acceptance, next pointer values, read-pointer decode and full/level estimates.
    always_comb begin
        mem_wen   = wen & ~wfull;
        wbin_nxt  = wbin + {{AW{1'b0}}, mem_wen};
        wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt;
        rbin_s    = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
        level_nxt = wbin_nxt - rbin_s;
        // Full when the next write pointer is exactly one lap ahead of the read pointer.
        wfull_val = (wgray_nxt == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]});
        ovf_set   = wen & wfull;
    end

    // Pointer, full, level and almost-full registers.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_nxt;
            wptr         <= wgray_nxt;
            wfull        <= wfull_val;
            walmost_full <= (level_nxt >= AFULL_LVL);
            wlevel       <= level_nxt;
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wovf <= 1'b0;
        end else if (ovf_set) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end

`ifdef WPTR_DROP_CNT_EN
    // Saturating dropped-write counter; clear beats a simultaneous increment.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wdrop_cnt <= '0;
        end else if (wovf_clr) begin
            wdrop_cnt <= '0;
        end else if (ovf_set && (wdrop_cnt != 16'hFFFF)) begin
            wdrop_cnt <= wdrop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - directed self-checking bench for wptr_full_ctrl
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       wrst;
    logic       wen;
    logic [4:0] wq2_rptr;
    logic [4:0] wptr;
    logic [3:0] mem_waddr;
    logic       mem_wen;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;
    logic       wovf_clr;
`ifdef WPTR_DROP_CNT_EN
    logic [15:0] wdrop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    wptr_full_ctrl #(.AW(4), .AFULL_TH(12)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .wen          (wen),
        .wq2_rptr     (wq2_rptr),
        .wptr         (wptr),
        .mem_waddr    (mem_waddr),
        .mem_wen      (mem_wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf),
`ifdef WPTR_DROP_CNT_EN
        .wdrop_cnt    (wdrop_cnt),
`endif
        .wovf_clr     (wovf_clr)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst = 1'b1; wen = 1'b0; wq2_rptr = '0; wovf_clr = 1'b0;
        tick();
        tick();
        checks++; if (wptr !== 5'd0) begin errors++; $display("FAIL reset_wptr: got %0h expected 0", wptr); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %0b expected 0", wfull); end
        checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel: got %0d expected 0", wlevel); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %0b expected 0", walmost_full); end
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL reset_wovf: got %0b expected 0", wovf); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen: got %0b expected 0", mem_wen); end
        wrst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        wq2_rptr = '0;
        wen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL fill_mem_wen[%0d]: got %0b expected 1", i, mem_wen); end
            checks++; if (mem_waddr !== 4'(i)) begin errors++; $display("FAIL fill_waddr[%0d]: got %0d expected %0d", i, mem_waddr, i); end
            tick();
            checks++; if (wptr !== gray(i + 1)) begin errors++; $display("FAIL fill_wptr[%0d]: got %b expected %b", i, wptr, gray(i + 1)); end
            if (i < 15) begin
                checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL fill_early_full[%0d]: got %0b expected 0", i, wfull); end
            end
        end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill_wfull: got %0b expected 1", wfull); end
        checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL fill_wptr_full: got %b expected 11000", wptr); end
        checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL fill_wlevel: got %0d expected 16", wlevel); end
        checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL fill_afull: got %0b expected 1", walmost_full); end
    endtask

    task automatic test_overflow();
        wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL ovf_mem_wen[%0d]: got %0b expected 0", i, mem_wen); end
            tick();
        end
        checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr: got %b expected 11000", wptr); end
        checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", wovf); end
        checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL ovf_wlevel: got %0d expected 16", wlevel); end
`ifdef WPTR_DROP_CNT_EN
        checks++; if (wdrop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 3", wdrop_cnt); end
`endif
        wovf_clr = 1'b1;
        tick();
        checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b expected 1", wovf); end
`ifdef WPTR_DROP_CNT_EN
        checks++; if (wdrop_cnt !== 16'd0) begin errors++; $display("FAIL ovf_drop_clr: got %0d expected 0", wdrop_cnt); end
`endif
        wen = 1'b0;
        tick();
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", wovf); end
        wovf_clr = 1'b0;
    endtask

    task automatic test_wrap();
        wq2_rptr = gray(1);
        wen = 1'b0;
        tick();
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL wrap_unfull: got %0b expected 0", wfull); end
        checks++; if (wlevel !== 5'd15) begin errors++; $display("FAIL wrap_level0: got %0d expected 15", wlevel); end
        for (int k = 2; k <= 16; k++) begin
            wq2_rptr = gray(k);
            wen = 1'b1;
            #1;
            checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL wrap_mem_wen[%0d]: got %0b expected 1", k, mem_wen); end
            checks++; if (mem_waddr !== 4'((14 + k) % 16)) begin errors++; $display("FAIL wrap_waddr[%0d]: got %0d expected %0d", k, mem_waddr, (14 + k) % 16); end
            tick();
            checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL wrap_spurious_full[%0d]: got %0b expected 0", k, wfull); end
            checks++; if (wlevel !== 5'd15) begin errors++; $display("FAIL wrap_level[%0d]: got %0d expected 15", k, wlevel); end
            checks++; if (wptr !== gray(15 + k)) begin errors++; $display("FAIL wrap_wptr[%0d]: got %b expected %b", k, wptr, gray(15 + k)); end
        end
        #1;
        checks++; if (mem_waddr !== 4'd15) begin errors++; $display("FAIL wrap_last_waddr: got %0d expected 15", mem_waddr); end
        tick();
        checks++; if (wptr !== 5'd0) begin errors++; $display("FAIL wrap_wptr_zero: got %b expected 00000", wptr); end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL wrap_full_again: got %0b expected 1", wfull); end
        checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL wrap_level_full: got %0d expected 16", wlevel); end
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL wrap_no_ovf: got %0b expected 0", wovf); end
        wen = 1'b0;
    endtask

    task automatic test_almost_full();
        wrst = 1'b1; wen = 1'b0; wq2_rptr = '0;
        tick();
        wrst = 1'b0;
        wen = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL afull_11: got %0b expected 0", walmost_full); end
        checks++; if (wlevel !== 5'd11) begin errors++; $display("FAIL afull_level11: got %0d expected 11", wlevel); end
        tick();
        checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL afull_12: got %0b expected 1", walmost_full); end
        checks++; if (wlevel !== 5'd12) begin errors++; $display("FAIL afull_level12: got %0d expected 12", wlevel); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL afull_not_full: got %0b expected 0", wfull); end
        wen = 1'b0;
    endtask

    task automatic test_reset_mid();
        wrst = 1'b1; wen = 1'b0; wq2_rptr = '0;
        tick();
        wrst = 1'b0;
        wen = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (wptr !== 5'b00100) begin errors++; $display("FAIL mid_wptr7: got %b expected 00100", wptr); end
        wrst = 1'b1;
        tick();
        checks++; if (wptr !== 5'd0) begin errors++; $display("FAIL mid_reset_wptr: got %b expected 00000", wptr); end
        checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL mid_reset_level: got %0d expected 0", wlevel); end
        wrst = 1'b0;
        #1;
        checks++; if (mem_waddr !== 4'd0) begin errors++; $display("FAIL mid_first_waddr: got %0d expected 0", mem_waddr); end
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL mid_first_wen: got %0b expected 1", mem_wen); end
        tick();
        checks++; if (wptr !== 5'b00001) begin errors++; $display("FAIL mid_after_wptr: got %b expected 00001", wptr); end
        checks++; if (wlevel !== 5'd1) begin errors++; $display("FAIL mid_after_level: got %0d expected 1", wlevel); end
        wen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_almost_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
